// File: rtl/washer_pkg.sv
// Shared types and constants for the wash/dryer cycle timer.
package washer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_DRY   = 3'd5,
      ST_DONE  = 3'd6
   } phase_t;

   localparam logic [3:0] CREDIT_COLD = 4'd1;
   localparam logic [3:0] CREDIT_HOT  = 4'd2;

   localparam logic [7:0] FILL_S_DEF  = 8'd10;
   localparam logic [7:0] WASH_S_DEF  = 8'd30;
   localparam logic [7:0] RINSE_S_DEF = 8'd20;
   localparam logic [7:0] SPIN_S_DEF  = 8'd15;
   localparam logic [7:0] DRY_S_DEF   = 8'd60;

endpackage

// File: rtl/wash_cycle_timer_if.sv
// Credit/switch inputs and display/actuator outputs of the cycle timer.
interface wash_cycle_timer_if;

   logic [3:0] credit;
   logic [5:0] SW;
   logic       bout;
   logic       busy;
   logic [2:0] phase;
   logic [7:0] secs_left;
   logic       valve;
   logic       motor;
   logic       heater;

   modport master (
      output credit, SW,
      input  bout, busy, phase, secs_left, valve, motor, heater
   );

   modport slave (
      input  credit, SW,
      output bout, busy, phase, secs_left, valve, motor, heater
   );

endinterface

// File: rtl/sec_prescaler.sv
// Divides the system clock down to a one-cycle tick every TICK_DIV enabled cycles.
module sec_prescaler #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic CLK100MHZ,
   input  logic CPU_RESETN,
   input  logic clr,
   input  logic en,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count;

   assign tick = en && (count == LAST);

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en) begin
         count <= tick ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/wash_cycle_timer.sv
// Runs the paid wash or dryer program, counting phase time in seconds and
// pulsing bout to the credit block when the program completes.
module wash_cycle_timer
   import washer_pkg::*;
#(
   parameter int         TICK_DIV = 100_000_000,
   parameter logic [7:0] FILL_S   = FILL_S_DEF,
   parameter logic [7:0] WASH_S   = WASH_S_DEF,
   parameter logic [7:0] RINSE_S  = RINSE_S_DEF,
   parameter logic [7:0] SPIN_S   = SPIN_S_DEF,
   parameter logic [7:0] DRY_S    = DRY_S_DEF
) (
   input  logic               CLK100MHZ,
   input  logic               CPU_RESETN,
   wash_cycle_timer_if.slave  bus
);

   phase_t     state, state_next;
   logic [7:0] secs_left, secs_next;
   logic       hot, hot_next;
   logic       tick, last_tick, pause, running;
   logic       valve_d, motor_d, heater_d, bout_d;
   logic       valve_q, motor_q, heater_q, bout_q;

   function automatic logic [7:0] phase_secs(input phase_t s);
      case (s)
         ST_FILL:  return FILL_S;
         ST_WASH:  return WASH_S;
         ST_RINSE: return RINSE_S;
         ST_SPIN:  return SPIN_S;
         ST_DRY:   return DRY_S;
         default:  return 8'd0;
      endcase
   endfunction

   assign pause     = bus.SW[5];
   assign running   = state inside {ST_FILL, ST_WASH, ST_RINSE, ST_SPIN, ST_DRY};
   assign last_tick = tick && (secs_left == 8'd1);

   // Prescaler restarts from zero on every phase entry and idles outside running phases.
   sec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .clr        (!running || last_tick),
      .en         (running && !pause),
      .tick       (tick)
   );

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         state     <= ST_IDLE;
         secs_left <= 8'd0;
         hot       <= 1'b0;
      end else begin
         state     <= state_next;
         secs_left <= secs_next;
         hot       <= hot_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (bus.SW[4]) begin
               if (bus.credit == CREDIT_HOT) state_next = ST_DRY;
            end else if ((|bus.SW[3:1]) &&
                         (bus.credit == CREDIT_COLD || bus.credit == CREDIT_HOT)) begin
               state_next = ST_FILL;
            end
         end
         ST_FILL:  if (last_tick) state_next = ST_WASH;
         ST_WASH:  if (last_tick) state_next = ST_RINSE;
         ST_RINSE: if (last_tick) state_next = ST_SPIN;
         ST_SPIN:  if (last_tick) state_next = ST_DONE;
         ST_DRY:   if (last_tick) state_next = ST_DONE;
         // Holding here until credit clears keeps a stale credit from restarting the program.
         ST_DONE:  if (bus.credit == 4'd0) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase

      hot_next = hot;
      if (state == ST_IDLE && state_next != ST_IDLE) hot_next = (bus.credit == CREDIT_HOT);

      secs_next = secs_left;
      if (state_next != state) begin
         secs_next = phase_secs(state_next);
      end else if (tick) begin
         secs_next = secs_left - 8'd1;
      end
   end

   always_comb begin
      bout_d   = (state != ST_DONE) && (state_next == ST_DONE);
      valve_d  = 1'b0;
      motor_d  = 1'b0;
      heater_d = 1'b0;
      if (!pause) begin
         valve_d  = state_next inside {ST_FILL, ST_RINSE};
         motor_d  = state_next inside {ST_WASH, ST_RINSE, ST_SPIN, ST_DRY};
         heater_d = ((state_next == ST_WASH) && hot_next) || (state_next == ST_DRY);
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (!CPU_RESETN) begin
         bout_q   <= 1'b0;
         valve_q  <= 1'b0;
         motor_q  <= 1'b0;
         heater_q <= 1'b0;
      end else begin
         bout_q   <= bout_d;
         valve_q  <= valve_d;
         motor_q  <= motor_d;
         heater_q <= heater_d;
      end
   end

   assign bus.bout      = bout_q;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.phase     = state;
   assign bus.secs_left = secs_left;
   assign bus.valve     = valve_q;
   assign bus.motor     = motor_q;
   assign bus.heater    = heater_q;

endmodule

// File: tb/tb_wash_cycle_timer.sv
// Self-checking bench for wash_cycle_timer: vector table, program sequences
// and randomized traffic against a phase-plan reference model.
module tb_wash_cycle_timer;

   localparam int TD = 4;

   logic CLK100MHZ = 1'b0;
   logic CPU_RESETN = 1'b0;

   wash_cycle_timer_if wif();

   wash_cycle_timer #(
      .TICK_DIV (TD),
      .FILL_S   (8'd2),
      .WASH_S   (8'd3),
      .RINSE_S  (8'd2),
      .SPIN_S   (8'd1),
      .DRY_S    (8'd3)
   ) dut (
      .CLK100MHZ  (CLK100MHZ),
      .CPU_RESETN (CPU_RESETN),
      .bus        (wif)
   );

   always #5 CLK100MHZ = ~CLK100MHZ;

   int passCount = 0;
   int checkCount = 0;

   // Reference model: the program is a queue of remaining phases plus elapsed un-paused cycles.
   int mPlan[$];
   bit mDone, mHot, mBout, mPause;
   int mElapsed;

   function automatic int durOf(input int ph);
      case (ph)
         1: return 2;
         2: return 3;
         3: return 2;
         4: return 1;
         5: return 3;
         default: return 0;
      endcase
   endfunction

   function void modelStep(input logic rstn, input logic [3:0] credit, input logic [5:0] sw);
      mBout  = 1'b0;
      mPause = sw[5];
      if (!rstn) begin
         mPlan.delete();
         mDone = 1'b0; mHot = 1'b0; mElapsed = 0;
      end else if (mDone) begin
         if (credit == 4'd0) mDone = 1'b0;
      end else if (mPlan.size() != 0) begin
         if (!sw[5]) begin
            mElapsed++;
            if (mElapsed == durOf(mPlan[0]) * TD) begin
               void'(mPlan.pop_front());
               mElapsed = 0;
               if (mPlan.size() == 0) begin
                  mDone = 1'b1;
                  mBout = 1'b1;
               end
            end
         end
      end else begin
         mElapsed = 0;
         if (sw[4]) begin
            if (credit == 4'd2) begin
               mPlan.push_back(5);
               mHot = 1'b1;
            end
         end else if (sw[3:1] != 3'b000 && (credit == 4'd1 || credit == 4'd2)) begin
            mPlan.push_back(1); mPlan.push_back(2); mPlan.push_back(3); mPlan.push_back(4);
            mHot = (credit == 4'd2);
         end
      end
   endfunction

   function logic [15:0] modelOutputs();
      int ph, secs;
      bit run;
      logic v, m, h;
      ph   = mDone ? 6 : ((mPlan.size() != 0) ? mPlan[0] : 0);
      run  = (ph >= 1 && ph <= 5);
      secs = run ? durOf(ph) - mElapsed / TD : 0;
      v    = run && !mPause && (ph == 1 || ph == 3);
      m    = run && !mPause && (ph >= 2 && ph <= 5);
      h    = run && !mPause && ((ph == 2 && mHot) || ph == 5);
      return {mBout, ph != 0, 3'(ph), 8'(secs), v, m, h};
   endfunction

   typedef struct {
      logic       rstn;
      logic [3:0] credit;
      logic [5:0] sw;
      logic [2:0] phase;
      logic [7:0] secs;
      logic       bout, busy, valve, motor, heater;
   } vec_t;

   vec_t vecs[15];

   int lens[8];
   int cyc, boutCount, boutAt, heaterCycles, heaterOutsideWash, dryBoth, quietWash;

   task applyStimulus(input logic rstn, input logic [3:0] credit, input logic [5:0] sw);
      CPU_RESETN = rstn;
      wif.credit = credit;
      wif.SW     = sw;
      @(posedge CLK100MHZ);
      modelStep(rstn, credit, sw);
      #1;
   endtask

   task reportMismatch(input string name, input logic [15:0] act, input logic [15:0] exp);
      $display("[TB] FAIL %s @%0t: got bout=%0b busy=%0b phase=%0d secs=%0d vmh=%0b%0b%0b, expected bout=%0b busy=%0b phase=%0d secs=%0d vmh=%0b%0b%0b",
               name, $time, act[15], act[14], act[13:11], act[10:3], act[2], act[1], act[0],
               exp[15], exp[14], exp[13:11], exp[10:3], exp[2], exp[1], exp[0]);
   endtask

   function logic [15:0] dutOutputs();
      return {wif.bout, wif.busy, wif.phase, wif.secs_left, wif.valve, wif.motor, wif.heater};
   endfunction

   task checkOutput(input string name);
      logic [15:0] exp, act;
      exp = modelOutputs();
      act = dutOutputs();
      checkCount++;
      if (act === exp) passCount++;
      else reportMismatch(name, act, exp);
   endtask

   task checkVector(input int idx);
      vec_t v;
      logic [15:0] exp, act;
      v   = vecs[idx];
      exp = {v.bout, v.busy, v.phase, v.secs, v.valve, v.motor, v.heater};
      act = dutOutputs();
      checkCount++;
      if (act === exp) passCount++;
      else reportMismatch($sformatf("vector %0d", idx), act, exp);
   endtask

   task checkValue(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) passCount++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task clearTally();
      foreach (lens[i]) lens[i] = 0;
      cyc = 0; boutCount = 0; boutAt = 0; heaterCycles = 0;
      heaterOutsideWash = 0; dryBoth = 0; quietWash = 0;
   endtask

   task tally();
      cyc++;
      lens[wif.phase]++;
      if (wif.bout) begin
         boutCount++;
         boutAt = cyc;
      end
      if (wif.heater) begin
         heaterCycles++;
         if (wif.phase != 3'd2) heaterOutsideWash++;
      end
      if (wif.phase == 3'd5 && wif.motor && wif.heater) dryBoth++;
      if (wif.phase == 3'd2 && !wif.valve && !wif.motor && !wif.heater) quietWash++;
   endtask

   task step(input logic rstn, input logic [3:0] credit, input logic [5:0] sw, input string name);
      applyStimulus(rstn, credit, sw);
      checkOutput(name);
      tally();
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int cr;
      int pausesUsed;
      logic [5:0] sw;
      logic rstn;

      //           rstn credit  sw          phase secs bout busy valve motor heater
      vecs[0]  = '{1'b0, 4'd0,  6'b000000, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 4'd1,  6'b010000, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 4'd3,  6'b000010, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 4'd0,  6'b000010, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, 4'd1,  6'b000001, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, 4'd15, 6'b010000, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, 4'd2,  6'b010010, 3'd5, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[7]  = '{1'b1, 4'd2,  6'b000000, 3'd5, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[8]  = '{1'b1, 4'd2,  6'b000000, 3'd5, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[9]  = '{1'b1, 4'd2,  6'b000000, 3'd5, 8'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[10] = '{1'b1, 4'd2,  6'b000000, 3'd5, 8'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      vecs[11] = '{1'b0, 4'd2,  6'b000000, 3'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 4'd1,  6'b000100, 3'd1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[13] = '{1'b1, 4'd1,  6'b100000, 3'd1, 8'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 4'd1,  6'b000000, 3'd1, 8'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      for (int i = 0; i < 15; i++) begin
         applyStimulus(vecs[i].rstn, vecs[i].credit, vecs[i].sw);
         checkVector(i);
      end

      // Cold wash with credit held after completion.
      step(1'b0, 4'd0, 6'b000000, "reset");
      clearTally();
      step(1'b1, 4'd1, 6'b000010, "cold start");
      for (int i = 0; i < 60 && wif.phase != 3'd6; i++) step(1'b1, 4'd1, 6'b000010, "cold run");
      for (int i = 0; i < 5; i++) step(1'b1, 4'd1, 6'b000010, "cold done hold");
      step(1'b1, 4'd0, 6'b000010, "cold release");
      checkValue("cold FILL cycles", lens[1], 8);
      checkValue("cold WASH cycles", lens[2], 12);
      checkValue("cold RINSE cycles", lens[3], 8);
      checkValue("cold SPIN cycles", lens[4], 4);
      checkValue("cold DONE cycles", lens[6], 6);
      checkValue("cold bout pulses", boutCount, 1);
      checkValue("cold bout cycle", boutAt, 33);
      checkValue("cold heater cycles", heaterCycles, 0);
      checkValue("cold back to IDLE", wif.phase, 0);

      // Hot wash with credit cleared mid-program.
      step(1'b0, 4'd0, 6'b000000, "reset");
      clearTally();
      step(1'b1, 4'd2, 6'b000100, "hot start");
      for (int i = 0; i < 80 && wif.phase != 3'd0; i++) step(1'b1, 4'd0, 6'b000000, "hot run");
      checkValue("hot heater cycles", heaterCycles, 12);
      checkValue("hot heater outside WASH", heaterOutsideWash, 0);
      checkValue("hot DONE cycles", lens[6], 1);
      checkValue("hot bout pulses", boutCount, 1);
      checkValue("hot back to IDLE", wif.phase, 0);

      // Dryer: needs two dollars; stale credit after DONE must not re-pulse bout.
      step(1'b0, 4'd0, 6'b000000, "reset");
      step(1'b1, 4'd1, 6'b010000, "dry cold credit");
      checkValue("dryer credit1 stays IDLE", wif.phase, 0);
      clearTally();
      step(1'b1, 4'd2, 6'b010000, "dry start");
      for (int i = 0; i < 40 && wif.phase != 3'd6; i++) step(1'b1, 4'd2, 6'b010000, "dry run");
      for (int i = 0; i < 5; i++) step(1'b1, 4'd2, 6'b010000, "dry stale credit");
      step(1'b1, 4'd0, 6'b010000, "dry release");
      checkValue("dry DRY cycles", lens[5], 12);
      checkValue("dry motor+heater cycles", dryBoth, 12);
      checkValue("dry DONE cycles", lens[6], 6);
      checkValue("dry bout pulses", boutCount, 1);
      checkValue("dry back to IDLE", wif.phase, 0);

      // Pause for 10 cycles in the middle of WASH.
      step(1'b0, 4'd0, 6'b000000, "reset");
      clearTally();
      pausesUsed = 0;
      step(1'b1, 4'd1, 6'b000010, "pause start");
      for (int i = 0; i < 120 && wif.phase != 3'd6; i++) begin
         if (wif.phase == 3'd2 && lens[2] >= 3 && pausesUsed < 10) begin
            pausesUsed++;
            step(1'b1, 4'd1, 6'b100010, "pause hold");
         end else begin
            step(1'b1, 4'd1, 6'b000010, "pause run");
         end
      end
      step(1'b1, 4'd0, 6'b000000, "pause release");
      checkValue("pause WASH cycles", lens[2], 22);
      checkValue("pause quiet WASH cycles", quietWash, 10);
      checkValue("pause bout pulses", boutCount, 1);

      // Reset during SPIN aborts without a bout pulse.
      step(1'b0, 4'd0, 6'b000000, "reset");
      clearTally();
      step(1'b1, 4'd1, 6'b000010, "abort start");
      for (int i = 0; i < 60 && wif.phase != 3'd4; i++) step(1'b1, 4'd1, 6'b000010, "abort run");
      checkValue("abort reached SPIN", wif.phase, 4);
      step(1'b0, 4'd1, 6'b000010, "abort reset");
      checkValue("abort outputs cleared", int'(dutOutputs()), 0);
      for (int i = 0; i < 6; i++) step(1'b1, 4'd0, 6'b000000, "abort idle");
      checkValue("abort bout pulses", boutCount, 0);

      // Randomized traffic against the model.
      step(1'b0, 4'd0, 6'b000000, "reset");
      cr = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(9) == 0) begin
            case ($urandom_range(4))
               0:       cr = 0;
               1:       cr = 1;
               2, 3:    cr = 2;
               default: cr = int'($urandom_range(15));
            endcase
         end
         sw    = 6'($urandom());
         sw[5] = ($urandom_range(5) == 0);
         rstn  = ($urandom_range(299) != 0);
         step(rstn, 4'(cr), sw, "random");
      end

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/wash_cycle_timer.md
# wash_cycle_timer

Cycle timer that consumes the credit held by the coin/credit block and runs the paid wash or dryer program. Durations are counted in seconds from the 100 MHz clock. At program end it emits the one-cycle borrow-out pulse that the credit block samples on its `bin` input to clear its count and light the completion LED. It also drives the machine actuators and the remaining-time and phase outputs for the display.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: clock cycles per one-second tick; must be at least 2.
- `FILL_S`, default 10: fill phase length, in seconds.
- `WASH_S`, default 30: wash phase length, in seconds.
- `RINSE_S`, default 20: rinse phase length, in seconds.
- `SPIN_S`, default 15: spin phase length, in seconds.
- `DRY_S`, default 60: dryer phase length, in seconds.
- All `*_S` parameters are 8-bit values in the range 1 to 255.

Ports:
- `CLK100MHZ`, in, 1 bit: the single system clock.
- `CPU_RESETN`, in, 1 bit: reset, synchronous and active-low.
- `credit`, in, 4 bits: dollar count from the credit block (0, 1 or 2).
- `SW`, in, 6 bits: `SW[1..3]` select a wash mode, `SW[4]` selects the dryer, `SW[5]` pauses the program, `SW[0]` is unused.
- `bout`, out, 1 bit: borrow-out; a one-cycle pulse at program completion, wired to `bin` of the credit block.
- `busy`, out, 1 bit: high from program start until the state returns to IDLE.
- `phase`, out, 3 bits: current state encoding.
- `secs_left`, out, 8 bits: seconds remaining in the current phase.
- `valve`, out, 1 bit: water valve.
- `motor`, out, 1 bit: drum motor.
- `heater`, out, 1 bit: heating element.

## Operation
- States and encodings: IDLE=0, FILL=1, WASH=2, RINSE=3, SPIN=4, DRY=5, DONE=6.
- Start is evaluated only in IDLE.
- Dryer start: `SW[4]`=1 and `credit`==2 → DRY. Any other credit value with `SW[4]`=1 does not start a program.
- Wash start: `SW[4]`=0, any of `SW[1..3]`=1, and `credit` of 1 or 2 → FILL.
- Credit value 0, or any value of 3 or more, never starts a program.
- At start, latch `hot` = (`credit`==2). After that, SW mode bits are ignored until the state is back in IDLE.
- Wash sequence: FILL → WASH → RINSE → SPIN → DONE.
- Dryer sequence: DRY → DONE.
- On entry to each phase:
  - `secs_left` is loaded with that phase's parameter.
  - The prescaler is cleared.
- Prescaler behaviour:
  - It counts from 0 to `TICK_DIV`-1.
  - The terminal count produces `tick`.
  - Each `tick` decrements `secs_left`.
  - A `tick` while `secs_left`==1 advances to the next phase instead of decrementing.
- Actuators, all registered and decoded from the state:
  - `valve` = FILL or RINSE.
  - `motor` = WASH, RINSE, SPIN or DRY.
  - `heater` = (WASH and `hot`) or DRY.
- Pause: while `SW[5]`=1 in any running phase:
  - The prescaler holds its value.
  - `motor` and `heater` are forced to 0.
  - `valve` is forced to 0.
  - The state and `secs_left` hold.
- DONE:
  - `bout` is asserted for exactly the one cycle in which DONE is entered.
  - The state then waits in DONE until `credit`==0, then returns to IDLE on the next cycle.
  - This rule prevents a stale credit from restarting the program.
  - `bout` is never re-asserted while the state stays in DONE.
- `busy` = state is not IDLE, including DONE.

## Timing
- Reset, when `CPU_RESETN`=0 is sampled at an edge:
  - The state becomes IDLE.
  - `bout`, `busy`, `valve`, `motor`, `heater` and `phase` all become 0.
  - `secs_left` becomes 0.
  - The prescaler and `hot` become 0.
  - Reset mid-program aborts the program with no `bout` pulse.
- Start latency: the start condition is sampled at edge N; at N+1 the state is the first phase, `secs_left` is loaded and the actuators are valid.
- Phase length: exactly `param` × `TICK_DIV` un-paused cycles.
- On the transition edge, `secs_left` is reloaded with the next phase's value in the same cycle.
- `bout` is high in the first cycle of DONE, one cycle after the final tick, and low in the next cycle.
- If `credit` is already 0 at the DONE entry edge+1, the state returns to IDLE at edge+2.
- If a tick and a pause assertion occur in the same cycle, the pause wins: the tick is not counted and the prescaler holds.

## Structure
- Package `washer_pkg`:
  - state/phase enum and encodings.
  - credit constants `CREDIT_COLD`=1 and `CREDIT_HOT`=2.
  - the default duration constants.
- Sub-module `sec_prescaler`:
  - Parameter: `TICK_DIV`.
  - Inputs: `clr`, `en`.
  - Output: `tick`.
  - Counter width: $clog2(`TICK_DIV`).
- Top level: the FSM, the `secs_left` down-counter and the actuator decode.

## Test plan
Bench parameters: `TICK_DIV`=4, `FILL_S`=2, `WASH_S`=3, `RINSE_S`=2, `SPIN_S`=1, `DRY_S`=3.
- Cold wash: `SW`=6'b000010, `credit`=1 → phases 1, 2, 3, 4 last 8, 12, 8 and 4 cycles; `heater` stays 0; `bout` is a single pulse 33 cycles after the start edge; DONE holds until `credit`=0, then IDLE.
- Hot wash: `credit`=2, `SW[2]`=1 → `heater` is 1 only during WASH (12 cycles); `hot` stays latched after `credit` is cleared mid-program.
- Dryer: `SW`=6'b010000 with `credit`=1 → stays IDLE; with `credit`=2 → DRY lasting 12 cycles with `motor`=`heater`=1, then a `bout` pulse.
- Pause: `SW[5]`=1 for 10 cycles during WASH → `secs_left` and the prescaler freeze with all actuators 0; total WASH length becomes 22 cycles.
- Reset mid-SPIN: `CPU_RESETN`=0 for 1 cycle → next cycle IDLE, all outputs 0, no `bout` pulse.
- Stale credit: `credit` held at 2 after DONE → stays DONE with no second `bout` pulse; dropping `credit` to 0 → IDLE 1 cycle later.
